// File: rtl/counter_8_monitor.sv
// Monitors a counter_8 sample stream: flags wraps, jumps and hysteretic threshold
// crossings, and queues one event per sample for a valid/ready consumer.
module counter_8_monitor #(
    parameter int unsigned HYST       = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] y_in,
    input  logic       up_in,
    input  logic [7:0] threshold,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_code,
    output logic [7:0] evt_value,
    output logic       above,
    output logic [7:0] ovf_count,
    output logic [7:0] unf_count,
    output logic [7:0] drop_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] EVT_NONE  = 3'd0;
    localparam logic [2:0] EVT_OVF   = 3'd1;
    localparam logic [2:0] EVT_UNF   = 3'd2;
    localparam logic [2:0] EVT_JUMP  = 3'd3;
    localparam logic [2:0] EVT_CUP   = 3'd4;
    localparam logic [2:0] EVT_CDOWN = 3'd5;

    typedef enum logic {
        ST_BELOW = 1'b0,
        ST_ABOVE = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] code;
        logic [7:0] value;
    } evt_t;

    state_e           state_q, state_d;
    logic [7:0]       prev_q, prev_d;
    logic             primed_q, primed_d;
    logic [7:0]       ovf_q, ovf_d;
    logic [7:0]       unf_q, unf_d;
    logic [7:0]       drop_q, drop_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    evt_t             mem_q [FIFO_DEPTH];

    logic [7:0] delta;
    logic [8:0] thr_lo;
    logic       thr_lo_ok;
    logic       is_ovf, is_unf, is_jump, cross_up, cross_dn;
    logic       push, pop, push_ok;
    evt_t       new_evt;
    evt_t       head;

    // Sample classification, hysteresis FSM, event selection and queue control
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        primed_d = primed_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        drop_d   = drop_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        new_evt  = '0;
        push     = 1'b0;

        delta     = y_in - prev_q;
        thr_lo    = {1'b0, threshold} - 9'(HYST);
        thr_lo_ok = {1'b0, threshold} > 9'(HYST);
        is_ovf    = primed_q && (prev_q == 8'hFF) && (y_in == 8'h00) && up_in;
        is_unf    = primed_q && (prev_q == 8'h00) && (y_in == 8'hFF) && !up_in;
        is_jump   = primed_q && !is_ovf && !is_unf &&
                    (delta != 8'h00) && (delta != 8'h01) && (delta != 8'hFF);
        cross_up  = (state_q == ST_BELOW) && (y_in >= threshold);
        cross_dn  = (state_q == ST_ABOVE) && thr_lo_ok && ({1'b0, y_in} < thr_lo);

        if (in_valid) begin
            prev_d   = y_in;
            primed_d = 1'b1;
            if (is_ovf && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
            if (is_unf && unf_q != 8'hFF) unf_d = unf_q + 8'd1;
            if (cross_up) state_d = ST_ABOVE;
            if (cross_dn) state_d = ST_BELOW;

            new_evt.value = y_in;
            if (is_ovf)        new_evt.code = EVT_OVF;
            else if (is_unf)   new_evt.code = EVT_UNF;
            else if (is_jump)  new_evt.code = EVT_JUMP;
            else if (cross_up) new_evt.code = EVT_CUP;
            else if (cross_dn) new_evt.code = EVT_CDOWN;
            else               new_evt.code = EVT_NONE;
            push = (new_evt.code != EVT_NONE);
        end

        // A full queue still accepts a push when the head leaves in the same cycle
        pop     = (cnt_q != '0) && evt_ready;
        push_ok = push && ((cnt_q != FULL_CNT) || pop);
        if (push && !push_ok && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

        if (push_ok) wr_d = wr_q + PTR_W'(1);
        if (pop)     rd_d = rd_q + PTR_W'(1);
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BELOW;
            prev_q   <= 8'h00;
            primed_q <= 1'b0;
            ovf_q    <= 8'h00;
            unf_q    <= 8'h00;
            drop_q   <= 8'h00;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            drop_q   <= drop_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    // Event storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_q] <= new_evt;
        end
    end

    assign head       = mem_q[rd_q];
    assign evt_valid  = (cnt_q != '0);
    assign evt_code   = evt_valid ? head.code  : 3'd0;
    assign evt_value  = evt_valid ? head.value : 8'd0;
    assign above      = (state_q == ST_ABOVE);
    assign ovf_count  = ovf_q;
    assign unf_count  = unf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_counter_8_monitor.sv
// Directed bench for counter_8_monitor: wraps, jumps, hysteresis, queue overflow and reset flush.
module tb_counter_8_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] y_in = 8'd0;
    logic       up_in = 1'b1;
    logic [7:0] threshold = 8'd255;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [2:0] evt_code;
    logic [7:0] evt_value;
    logic       above;
    logic [7:0] ovf_count, unf_count, drop_count;

    int total = 0;
    int bad   = 0;

    counter_8_monitor #(.HYST(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in), .up_in(up_in),
        .threshold(threshold), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_value(evt_value), .above(above),
        .ovf_count(ovf_count), .unf_count(unf_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; in_valid = 1'b0; evt_ready = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic sample(input logic [7:0] y, input logic up, input logic rdy);
        @(negedge clk); in_valid = 1'b1; y_in = y; up_in = up; evt_ready = rdy;
        @(posedge clk); #1; in_valid = 1'b0; evt_ready = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk); evt_ready = 1'b1;
        @(posedge clk); #1; evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", evt_valid); end
        total++; if (evt_code !== 3'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", evt_code); end
        total++; if (evt_value !== 8'd0) begin bad++; $display("FAIL reset_value got=%0d exp=0", evt_value); end
        total++; if (above !== 1'b0) begin bad++; $display("FAIL reset_above got=%0d exp=0", above); end
        total++; if ({ovf_count, unf_count, drop_count} !== 24'd0) begin bad++;
            $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", ovf_count, unf_count, drop_count); end
    endtask

    // threshold 0: first sample crosses up, no later crossing is possible
    task automatic test_overflow();
        do_reset(); threshold = 8'd0;
        sample(8'd254, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd4 || evt_value !== 8'd254) begin bad++;
            $display("FAIL ovf_first_latency got=%0d/%0d/%0d exp=1/4/254", evt_valid, evt_code, evt_value); end
        sample(8'd255, 1'b1, 1'b0);
        sample(8'd0, 1'b1, 1'b0);
        total++; if (ovf_count !== 8'd1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", ovf_count); end
        total++; if (unf_count !== 8'd0) begin bad++; $display("FAIL ovf_unf_count got=%0d exp=0", unf_count); end
        pop_one();
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd1 || evt_value !== 8'd0) begin bad++;
            $display("FAIL ovf_event got=%0d/%0d/%0d exp=1/1/0", evt_valid, evt_code, evt_value); end
        pop_one();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", evt_valid); end
    endtask

    task automatic test_underflow();
        do_reset(); threshold = 8'd0;
        sample(8'd1, 1'b0, 1'b0);
        sample(8'd0, 1'b0, 1'b0);
        sample(8'd255, 1'b0, 1'b0);
        total++; if (unf_count !== 8'd1) begin bad++; $display("FAIL unf_count got=%0d exp=1", unf_count); end
        total++; if (ovf_count !== 8'd0) begin bad++; $display("FAIL unf_ovf_count got=%0d exp=0", ovf_count); end
        pop_one();
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd2 || evt_value !== 8'd255) begin bad++;
            $display("FAIL unf_event got=%0d/%0d/%0d exp=1/2/255", evt_valid, evt_code, evt_value); end
        pop_one();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL unf_drained got=%0d exp=0", evt_valid); end
    endtask

    task automatic test_hysteresis();
        logic [7:0] ys [5];
        logic       exp_above [5];
        ys = '{8'd99, 8'd100, 8'd99, 8'd98, 8'd97};
        exp_above = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset(); threshold = 8'd100;
        for (int i = 0; i < 5; i++) begin
            sample(ys[i], 1'b1, 1'b0);
            total++; if (above !== exp_above[i]) begin bad++;
                $display("FAIL hyst_above[%0d] got=%0d exp=%0d", i, above, exp_above[i]); end
        end
        total++; if (evt_code !== 3'd4 || evt_value !== 8'd100) begin bad++;
            $display("FAIL hyst_cross_up got=%0d/%0d exp=4/100", evt_code, evt_value); end
        pop_one();
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd5 || evt_value !== 8'd97) begin bad++;
            $display("FAIL hyst_cross_down got=%0d/%0d/%0d exp=1/5/97", evt_valid, evt_code, evt_value); end
        pop_one();
        // threshold <= HYST: no cross_down ever, the drop to 0 is only a jump
        do_reset(); threshold = 8'd2;
        sample(8'd5, 1'b1, 1'b1);
        sample(8'd0, 1'b1, 1'b0);
        total++; if (above !== 1'b1) begin bad++; $display("FAIL hyst_floor_above got=%0d exp=1", above); end
        pop_one();
        total++; if (evt_code !== 3'd3 || evt_value !== 8'd0) begin bad++;
            $display("FAIL hyst_floor_event got=%0d/%0d exp=3/0", evt_code, evt_value); end
    endtask

    task automatic test_jump();
        do_reset(); threshold = 8'd255;
        sample(8'd10, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL jump_first_none got=%0d exp=0", evt_valid); end
        sample(8'd50, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd3 || evt_value !== 8'd50) begin bad++;
            $display("FAIL jump_event got=%0d/%0d/%0d exp=1/3/50", evt_valid, evt_code, evt_value); end
        do_reset();
        sample(8'd200, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL jump_after_reset got=%0d exp=0", evt_valid); end
        sample(8'd201, 1'b1, 1'b0);
        sample(8'd200, 1'b0, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL jump_normal_step got=%0d exp=0", evt_valid); end
    endtask

    task automatic test_queue_full();
        do_reset(); threshold = 8'd255;
        sample(8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) sample(8'(i * 10), 1'b1, 1'b0);
        total++; if (drop_count !== 8'd2) begin bad++; $display("FAIL full_drop_count got=%0d exp=2", drop_count); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd3 || evt_value !== 8'd10) begin bad++;
            $display("FAIL full_head_stable got=%0d/%0d/%0d exp=1/3/10", evt_valid, evt_code, evt_value); end
        for (int i = 1; i <= 4; i++) begin
            total++; if (evt_valid !== 1'b1 || evt_value !== 8'(i * 10)) begin bad++;
                $display("FAIL full_drain[%0d] got=%0d/%0d exp=1/%0d", i, evt_valid, evt_value, i * 10); end
            pop_one();
        end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%0d exp=0", evt_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset(); threshold = 8'd255;
        sample(8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) sample(8'(i * 10), 1'b1, 1'b0);
        sample(8'd90, 1'b1, 1'b1);
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL b2b_drop got=%0d exp=0", drop_count); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_v;
            exp_v = (i < 3) ? 8'((i + 2) * 10) : 8'd90;
            total++; if (evt_valid !== 1'b1 || evt_value !== exp_v) begin bad++;
                $display("FAIL b2b_drain[%0d] got=%0d/%0d exp=1/%0d", i, evt_valid, evt_value, exp_v); end
            pop_one();
        end
    endtask

    task automatic test_saturation();
        do_reset(); threshold = 8'd255;
        sample(8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) sample((i % 2 == 0) ? 8'd128 : 8'd0, 1'b1, 1'b0);
        total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL sat_drop got=%0d exp=255", drop_count); end
        for (int i = 0; i < 300; i++) begin
            sample(8'd255, 1'b1, 1'b0);
            sample(8'd0, 1'b1, 1'b0);
        end
        total++; if (ovf_count !== 8'd255) begin bad++; $display("FAIL sat_ovf got=%0d exp=255", ovf_count); end
    endtask

    task automatic test_reset_flush();
        do_reset(); threshold = 8'd255;
        sample(8'd255, 1'b1, 1'b0);
        sample(8'd0, 1'b1, 1'b0);
        sample(8'd10, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b1 || ovf_count !== 8'd1 || above !== 1'b0) begin bad++;
            $display("FAIL flush_pre got=%0d/%0d/%0d exp=1/1/0", evt_valid, ovf_count, above); end
        @(negedge clk); rst = 1'b1; in_valid = 1'b1; y_in = 8'd30; evt_ready = 1'b1;
        @(posedge clk); #1; rst = 1'b0; in_valid = 1'b0; evt_ready = 1'b0;
        total++; if (evt_valid !== 1'b0 || ovf_count !== 8'd0 || drop_count !== 8'd0) begin bad++;
            $display("FAIL flush_post got=%0d/%0d/%0d exp=0/0/0", evt_valid, ovf_count, drop_count); end
        sample(8'd200, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL flush_first got=%0d exp=0", evt_valid); end
        sample(8'd100, 1'b1, 1'b0);
        total++; if (evt_code !== 3'd3 || evt_value !== 8'd100) begin bad++;
            $display("FAIL flush_primed got=%0d/%0d exp=3/100", evt_code, evt_value); end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_underflow();
        test_hysteresis();
        test_jump();
        test_queue_full();
        test_back_to_back();
        test_saturation();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
